// File: rtl/llac_mixer_pkg.sv
// Shared types and sizing helpers for the LLAC core mixer.
package llac_mixer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        SAT,
        OUT
    } mixer_state_t;

    localparam int DEFAULT_GAIN_WIDTH = 16;
    localparam int GAIN_UNITY         = 1 << (DEFAULT_GAIN_WIDTH - 1);

    // Wide enough for NUM_CORES full-scale products without overflow.
    function automatic int acc_width(input int audio_w, input int gain_w, input int cores);
        return audio_w + gain_w + 1 + $clog2(cores);
    endfunction

endpackage

// File: rtl/llac_mixer_saturate.sv
// Combinational arithmetic shift (floor) followed by a clamp to the signed OUT_W range.
module llac_mixer_saturate #(
    parameter int IN_W  = 43,
    parameter int OUT_W = 24,
    parameter int SHIFT = 15
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    clipped
);

    localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [IN_W-1:0] shifted;

    always_comb begin
        shifted = din >>> SHIFT;
        dout    = shifted[OUT_W-1:0];
        clipped = 1'b0;
        if (shifted > MAX_V) begin
            dout    = MAX_V[OUT_W-1:0];
            clipped = 1'b1;
        end else if (shifted < MIN_V) begin
            dout    = MIN_V[OUT_W-1:0];
            clipped = 1'b1;
        end
    end

endmodule

// File: rtl/llac_core_mixer.sv
// Time-multiplexed stereo mixer: one core per cycle, saturate, valid/ready output.
// Optional clip counter enabled by defining LLAC_MIXER_CLIP_COUNT_EN.
module llac_core_mixer
    import llac_mixer_pkg::*;
#(
    parameter int NUM_CORES   = 4,
    parameter int AUDIO_WIDTH = 24,
    parameter int GAIN_WIDTH  = 16
) (
    input  logic                             clk_100mhz,
    input  logic                             resetn,
    input  logic [NUM_CORES*AUDIO_WIDTH-1:0] in_left,
    input  logic [NUM_CORES*AUDIO_WIDTH-1:0] in_right,
    input  logic                             in_valid,
    input  logic [NUM_CORES*GAIN_WIDTH-1:0]  gain,
    output logic [AUDIO_WIDTH-1:0]           out_left,
    output logic [AUDIO_WIDTH-1:0]           out_right,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             overrun,
    input  logic [NUM_CORES-1:0]             core_pause,
    input  logic [NUM_CORES-1:0]             core_stop,
    input  logic [NUM_CORES-1:0]             core_resume,
    output logic [NUM_CORES-1:0]             core_status,
    output logic [NUM_CORES-1:0]             core_interrupt
`ifdef LLAC_MIXER_CLIP_COUNT_EN
    ,
    input  logic                             clip_clear,
    output logic [15:0]                      clip_count
`endif
);

    localparam int ACC_W  = acc_width(AUDIO_WIDTH, GAIN_WIDTH, NUM_CORES);
    localparam int PROD_W = AUDIO_WIDTH + GAIN_WIDTH + 1;
    localparam int IDX_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    mixer_state_t                  state_reg;
    logic [IDX_W-1:0]              idx_reg;
    logic signed [AUDIO_WIDTH-1:0] samp_l_reg [NUM_CORES];
    logic signed [AUDIO_WIDTH-1:0] samp_r_reg [NUM_CORES];
    logic [GAIN_WIDTH-1:0]         gain_reg   [NUM_CORES];
    logic [NUM_CORES-1:0]          active_mask_reg;
    logic [NUM_CORES-1:0]          core_status_reg;
    logic [NUM_CORES-1:0]          core_interrupt_reg;
    logic signed [ACC_W-1:0]       acc_l_reg;
    logic signed [ACC_W-1:0]       acc_r_reg;
    logic [AUDIO_WIDTH-1:0]        out_left_reg;
    logic [AUDIO_WIDTH-1:0]        out_right_reg;
    logic                          out_valid_reg;
    logic                          overrun_reg;

    logic signed [PROD_W-1:0]      prod_l;
    logic signed [PROD_W-1:0]      prod_r;
    logic signed [AUDIO_WIDTH-1:0] sat_l;
    logic signed [AUDIO_WIDTH-1:0] sat_r;
    logic                          clip_l;
    logic                          clip_r;

    // Gain is unsigned, so it gets a zero sign bit before the signed multiply.
    assign prod_l = PROD_W'(samp_l_reg[idx_reg]) * PROD_W'($signed({1'b0, gain_reg[idx_reg]}));
    assign prod_r = PROD_W'(samp_r_reg[idx_reg]) * PROD_W'($signed({1'b0, gain_reg[idx_reg]}));

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CORES; gi++) begin : g_core
            always_ff @(posedge clk_100mhz) begin
                if (state_reg == IDLE && in_valid) begin
                    samp_l_reg[gi] <= in_left[gi*AUDIO_WIDTH +: AUDIO_WIDTH];
                    samp_r_reg[gi] <= in_right[gi*AUDIO_WIDTH +: AUDIO_WIDTH];
                    gain_reg[gi]   <= gain[gi*GAIN_WIDTH +: GAIN_WIDTH];
                end
            end

            // Stop outranks pause, which outranks resume.
            always_ff @(posedge clk_100mhz) begin
                if (!resetn) begin
                    core_status_reg[gi]    <= 1'b0;
                    core_interrupt_reg[gi] <= 1'b0;
                end else if (core_stop[gi]) begin
                    core_status_reg[gi]    <= 1'b0;
                    core_interrupt_reg[gi] <= 1'b1;
                end else if (core_pause[gi]) begin
                    core_status_reg[gi]    <= 1'b0;
                end else if (core_resume[gi]) begin
                    core_status_reg[gi]    <= 1'b1;
                    core_interrupt_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    llac_mixer_saturate #(.IN_W(ACC_W), .OUT_W(AUDIO_WIDTH), .SHIFT(GAIN_WIDTH-1)) u_sat_left (
        .din     (acc_l_reg),
        .dout    (sat_l),
        .clipped (clip_l)
    );

    llac_mixer_saturate #(.IN_W(ACC_W), .OUT_W(AUDIO_WIDTH), .SHIFT(GAIN_WIDTH-1)) u_sat_right (
        .din     (acc_r_reg),
        .dout    (sat_r),
        .clipped (clip_r)
    );

    always_ff @(posedge clk_100mhz) begin
        if (!resetn) begin
            state_reg       <= IDLE;
            idx_reg         <= '0;
            acc_l_reg       <= '0;
            acc_r_reg       <= '0;
            active_mask_reg <= '0;
            out_left_reg    <= '0;
            out_right_reg   <= '0;
            out_valid_reg   <= 1'b0;
            overrun_reg     <= 1'b0;
        end else begin
            overrun_reg <= in_valid && (state_reg != IDLE);
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        active_mask_reg <= core_status_reg;
                        acc_l_reg       <= '0;
                        acc_r_reg       <= '0;
                        idx_reg         <= '0;
                        state_reg       <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (active_mask_reg[idx_reg]) begin
                        acc_l_reg <= acc_l_reg + ACC_W'(prod_l);
                        acc_r_reg <= acc_r_reg + ACC_W'(prod_r);
                    end
                    if (idx_reg == IDX_W'(NUM_CORES-1)) begin
                        state_reg <= SAT;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                SAT: begin
                    out_left_reg  <= sat_l;
                    out_right_reg <= sat_r;
                    out_valid_reg <= 1'b1;
                    state_reg     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign out_left       = out_left_reg;
    assign out_right      = out_right_reg;
    assign out_valid      = out_valid_reg;
    assign overrun        = overrun_reg;
    assign core_status    = core_status_reg;
    assign core_interrupt = core_interrupt_reg;

`ifdef LLAC_MIXER_CLIP_COUNT_EN
    logic [15:0] clip_count_reg;

    always_ff @(posedge clk_100mhz) begin
        if (!resetn) begin
            clip_count_reg <= '0;
        end else if (clip_clear) begin
            clip_count_reg <= '0;
        end else if (state_reg == SAT && (clip_l || clip_r) && clip_count_reg != 16'hFFFF) begin
            clip_count_reg <= clip_count_reg + 16'd1;
        end
    end

    assign clip_count = clip_count_reg;
`else
    logic unused_clip_flags;
    assign unused_clip_flags = clip_l | clip_r;
`endif

endmodule
